// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine-timer slave: register indices decoded
// from address[4:2] and bit positions inside the CTRL register.
package mtimer_pkg;

  localparam logic [2:0] MTIME_LO_IDX    = 3'd0;
  localparam logic [2:0] MTIME_HI_IDX    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO_IDX = 3'd2;
  localparam logic [2:0] MTIMECMP_HI_IDX = 3'd3;
  localparam logic [2:0] CTRL_IDX        = 3'd4;
  localparam logic [2:0] PRESCALE_IDX    = 3'd5;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick generator for the machine timer. A down-counter reloads from
// `period` after reaching zero, so one tick is produced every period+1
// enabled cycles. A load forces the counter to a new value at once, and a
// cleared enable freezes the count where it is.
module mtimer_prescaler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  assign tick = enable & (count == '0);

  // Countdown with reload on zero; an explicit load takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      if (count == '0) count <= period;
      else             count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mtimer_slave.sv
// Memory-mapped machine timer on the 32-bit peripheral slave port.
// Holds a 64-bit free-running mtime, a 64-bit mtimecmp and a CTRL register
// and drives a registered level interrupt when mtime >= mtimecmp.
// Optional feature: define MTIMER_PRESCALER_EN to add the PRESCALE register
// and a tick divider; without it mtime advances every enabled cycle.
module mtimer_slave
  import mtimer_pkg::*;
#(
  parameter logic [63:0] RESET_CMP       = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          PRESCALER_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        timer_irq
);

  logic [2:0]  idx;
  logic        rd_en;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] hi_snap;
  logic [1:0]  ctrl;
  logic        tick;
  logic [31:0] rd_mux;
  logic [PRESCALER_WIDTH-1:0] prescale;

  // Only address[4:2] selects a register; the rest of the bus address is
  // don't-care for this slave.
  logic unused_addr;
  assign unused_addr = ^{address[31:5], address[1:0]};

  assign idx = address[4:2];
  // A write in the same cycle as a read wins and the read is discarded.
  assign rd_en = read & ~write;

`ifdef MTIMER_PRESCALER_EN
  logic wr_prescale;
  assign wr_prescale = write & (idx == PRESCALE_IDX);

  // Divider setting; writing it also restarts the divider count.
  always_ff @(posedge clk) begin
    if (reset)            prescale <= '0;
    else if (wr_prescale) prescale <= write_data[PRESCALER_WIDTH-1:0];
  end

  mtimer_prescaler #(
    .WIDTH(PRESCALER_WIDTH)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .enable     (ctrl[CTRL_ENABLE_BIT]),
    .load       (wr_prescale),
    .load_value (write_data[PRESCALER_WIDTH-1:0]),
    .period     (prescale),
    .tick       (tick)
  );
`else
  assign prescale = '0;
  assign tick     = ctrl[CTRL_ENABLE_BIT];
`endif

  // mtime: a write to either half replaces that half and swallows the tick
  // for this cycle; the other half is left untouched (no carry).
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime <= '0;
    end else if (write && idx == MTIME_LO_IDX) begin
      mtime[31:0] <= write_data;
    end else if (write && idx == MTIME_HI_IDX) begin
      mtime[63:32] <= write_data;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Compare register and control bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp <= RESET_CMP;
      ctrl     <= '0;
    end else if (write) begin
      case (idx)
        MTIMECMP_LO_IDX: mtimecmp[31:0]  <= write_data;
        MTIMECMP_HI_IDX: mtimecmp[63:32] <= write_data;
        CTRL_IDX:        ctrl            <= write_data[1:0];
        default: ;
      endcase
    end
  end

  // Read multiplexer; MTIME_HI returns the snapshot taken at the last LO read.
  always_comb begin
    rd_mux = '0;
    case (idx)
      MTIME_LO_IDX:    rd_mux = mtime[31:0];
      MTIME_HI_IDX:    rd_mux = hi_snap;
      MTIMECMP_LO_IDX: rd_mux = mtimecmp[31:0];
      MTIMECMP_HI_IDX: rd_mux = mtimecmp[63:32];
      CTRL_IDX:        rd_mux = {30'd0, ctrl};
      PRESCALE_IDX:    rd_mux = 32'(prescale);
      default:         rd_mux = '0;
    endcase
  end

  // Registered read data plus the upper-half snapshot for atomic 64-bit reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= '0;
      hi_snap   <= '0;
    end else if (rd_en) begin
      read_data <= rd_mux;
      if (idx == MTIME_LO_IDX) hi_snap <= mtime[63:32];
    end
  end

  // Level interrupt, one cycle behind the compare.
  always_ff @(posedge clk) begin
    if (reset) timer_irq <= 1'b0;
    else       timer_irq <= ctrl[CTRL_IRQ_EN_BIT] & (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_mtimer_slave.sv
// Self-checking bench for mtimer_slave: directed scenarios with literal
// expectations, then randomized bus traffic checked every cycle against a
// transaction-level model of the timer.
module tb_mtimer_slave;

  localparam int PW = 16;

  logic        clk;
  logic        reset;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        timer_irq;

  int checks   = 0;
  int failures = 0;

  mtimer_slave #(
    .RESET_CMP       (64'hFFFF_FFFF_FFFF_FFFF),
    .PRESCALER_WIDTH (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .read       (read),
    .write      (write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // State is kept as whole 64-bit numbers; the divider is modelled as a
  // count of enabled cycles since the last reload.
  logic [63:0] m_mt, m_cmp;
  logic [31:0] m_snap, m_rd;
  logic [1:0]  m_ctrl;
  logic        m_irq;
  int unsigned m_ps, m_el;
  bit          m_valid = 0;
  bit          m_tick;
  logic [2:0]  m_i;

  function automatic logic [31:0] m_reg(input logic [2:0] i);
    case (i)
      3'd0: return m_mt[31:0];
      3'd1: return m_snap;
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'd0, m_ctrl};
`ifdef MTIMER_PRESCALER_EN
      3'd5: return m_ps;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mt = 0; m_cmp = '1; m_snap = 0; m_rd = 0; m_ctrl = 0;
      m_irq = 0; m_ps = 0; m_el = 0; m_valid = 1;
    end else if (m_valid) begin
      m_i = address[4:2];
`ifdef MTIMER_PRESCALER_EN
      m_tick = m_ctrl[0] && ((m_el % (m_ps + 1)) == m_ps);
      if (m_ctrl[0]) m_el++;
`else
      m_tick = m_ctrl[0];
`endif
      m_irq = m_ctrl[1] && (m_mt >= m_cmp);
      if (read && !write) begin
        m_rd = m_reg(m_i);
        if (m_i == 3'd0) m_snap = m_mt[63:32];
      end
      if (write && m_i == 3'd0)      m_mt[31:0]  = write_data;
      else if (write && m_i == 3'd1) m_mt[63:32] = write_data;
      else if (m_tick)               m_mt = m_mt + 64'd1;
      if (write) begin
        case (m_i)
          3'd2: m_cmp[31:0]  = write_data;
          3'd3: m_cmp[63:32] = write_data;
          3'd4: m_ctrl       = write_data[1:0];
`ifdef MTIMER_PRESCALER_EN
          3'd5: begin m_ps = write_data & 32'h0000_FFFF; m_el = 0; end
`endif
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_read_data", {32'd0, read_data}, {32'd0, m_rd});
      chk("model_timer_irq", {63'd0, timer_irq}, {63'd0, m_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic op(input bit r, input bit w, input logic [2:0] i, input logic [31:0] d);
    read = r; write = w; address = {27'd0, i, 2'b00}; write_data = d;
    @(posedge clk); #1;
    read = 0; write = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [2:0] i, input logic [31:0] d);
    op(1'b0, 1'b1, i, d);
  endtask

  task automatic rd(input logic [2:0] i);
    op(1'b1, 1'b0, i, 32'd0);
  endtask

  task automatic check_reset_regs();
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      chk($sformatf("reset_reg%0d", i), {32'd0, read_data},
          (i == 2 || i == 3) ? 64'h0000_0000_FFFF_FFFF : 64'd0);
    end
    chk("reset_irq", {63'd0, timer_irq}, 64'd0);
  endtask

  initial begin
    reset = 1; read = 0; write = 0; address = 0; write_data = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset values of all eight indices.
    check_reset_regs();

    // Carry across halves and atomic HI read.
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd1, 32'd0);
    wr(3'd4, 32'd1);
    idle(3);
    rd(3'd0);
    chk("carry_lo", {32'd0, read_data}, 64'd1);
    rd(3'd1);
    chk("carry_hi", {32'd0, read_data}, 64'd1);
    idle(5);
    rd(3'd1);
    chk("snap_hi_held", {32'd0, read_data}, 64'd1);

    // Compare interrupt timing.
    wr(3'd4, 32'd0);
    wr(3'd2, 32'd10);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd4, 32'd3);
    idle(10);
    chk("irq_before", {63'd0, timer_irq}, 64'd0);
    idle(1);
    chk("irq_rise", {63'd0, timer_irq}, 64'd1);
    wr(3'd2, 32'd100);
    chk("irq_lag", {63'd0, timer_irq}, 64'd1);
    idle(1);
    chk("irq_drop", {63'd0, timer_irq}, 64'd0);

    // Write to mtime on a tick cycle wins, then read+write holds read_data.
    wr(3'd0, 32'd5);
    idle(2);
    rd(3'd0);
    chk("write_wins", {32'd0, read_data}, 64'd7);
    op(1'b1, 1'b1, 3'd4, 32'd3);
    chk("rw_hold", {32'd0, read_data}, 64'd7);

`ifdef MTIMER_PRESCALER_EN
    wr(3'd4, 32'd0);
    wr(3'd5, 32'd3);
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd4, 32'd1);
    idle(40);
    rd(3'd0);
    chk("prescale_count", {32'd0, read_data}, 64'd10);
    rd(3'd5);
    chk("prescale_read", {32'd0, read_data}, 64'd3);
`else
    wr(3'd5, 32'd3);
    rd(3'd5);
    chk("prescale_absent", {32'd0, read_data}, 64'd0);
`endif

    // Reset mid-count while interrupt is asserted.
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd4, 32'd3);
    idle(2);
    chk("irq_before_reset", {63'd0, timer_irq}, 64'd1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_read_data", {32'd0, read_data}, 64'd0);
    chk("rst_irq", {63'd0, timer_irq}, 64'd0);
    check_reset_regs();

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 600; n++) begin
      int kind;
      logic [31:0] d;
      kind = int'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: d = 32'd0;
        1: d = $urandom_range(0, 40);
        2: d = 32'hFFFF_FFFF;
        3: d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        4: d = $urandom_range(0, 3);
        default: d = $urandom;
      endcase
      read       = (kind == 1 || kind == 3);
      write      = (kind == 2 || kind == 3);
      address    = $urandom;
      write_data = d;
      reset      = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    read = 0; write = 0; reset = 0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtimer_slave.md
# mtimer_slave

Memory-mapped machine-timer responder for the Risco-5 peripheral bus: the slave end of the bus read/write protocol that the interconnect routes to. It holds a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and a control register, all accessible over the 32-bit slave port. It raises a level timer interrupt toward the core. It attaches to any slave slot of the bus: `slave_N_*` wires connect one-to-one to its ports.

## Interface
- `RESET_CMP`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.
- `PRESCALER_WIDTH`, default 16: width of the prescale register and counter; only used with `MTIMER_PRESCALER_EN`.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `read` input, 1: read strobe from the bus, one cycle per access.
- `write` input, 1: write strobe from the bus, one cycle per access.
- `address` input, 32: byte address; only `address[4:2]` decoded, `[1:0]` ignored.
- `write_data` input, 32: write payload.
- `read_data` output, 32: registered read payload.
- `timer_irq` output, 1: registered level interrupt.

## Operation
- Register map by `address[4:2]`:
  - 0 `MTIME_LO`: RW.
  - 1 `MTIME_HI`: RW; reads return the snapshot.
  - 2 `MTIMECMP_LO`: RW.
  - 3 `MTIMECMP_HI`: RW.
  - 4 `CTRL`: bit0 `enable`, bit1 `irq_en`; others read 0.
  - 5 `PRESCALE`: RW with the macro; reads 0 and ignores writes without it.
  - 6–7: read 0, writes ignored.
- Counting: when `enable`=1, `mtime` increments by 1 on each tick; it wraps from 2^64−1 to 0 silently.
- Atomic 64-bit read: a read of `MTIME_LO` returns `mtime[31:0]` and in the same edge latches `mtime[63:32]` into `hi_snap`. A read of `MTIME_HI` returns `hi_snap`, not the live value.
- Compare: `match = (mtime >= mtimecmp)`, unsigned 64-bit. `timer_irq <= irq_en & match`. Writing `mtimecmp` above `mtime` deasserts the interrupt; there is no sticky pending bit.
- Simultaneous events:
  - Write to `MTIME_LO`/`MTIME_HI` on a tick cycle: write wins, that tick is dropped, and the other half is unchanged (no carry propagation).
  - `read` and `write` in the same cycle: the write executes; `read_data` holds its previous value.
  - `read` with no `write`: `read_data` is loaded; when neither strobe is active, `read_data` holds.
- Reset (any cycle, including mid-count):
  - `mtime`=0, `hi_snap`=0, `mtimecmp`=`RESET_CMP`, `CTRL`=0, `PRESCALE`=0, prescale counter=0.
  - `read_data`=0, `timer_irq`=0.

## Timing
- Read latency is 1 cycle: `read` high at edge N puts data on `read_data` after edge N, where it is sampled by the master in cycle N+1.
- Write takes effect at the edge where `write` is sampled high; register readback on the next read reflects it.
- Tick without the macro: every cycle while `enable`=1. The first increment is at the edge after the `CTRL` write that sets `enable`.
- `timer_irq` lags `match` by 1 cycle: `mtime` reaching `mtimecmp` at edge N raises `timer_irq` after edge N+1.
- There are no wait states and no ready signal; every access completes in one bus cycle.

## Configuration
- Macro: `MTIMER_PRESCALER_EN`.
- Defined:
  - A `PRESCALER_WIDTH`-bit down-counter reloads from `PRESCALE` and ticks when it reaches 0; the tick period is `PRESCALE`+1 cycles.
  - Writing `PRESCALE` reloads the counter immediately.
  - Clearing `enable` freezes the counter.
- Undefined: no prescale logic; register 5 reads 0; a tick occurs every enabled cycle.

## Structure
- Shared package `mtimer_pkg`:
  - Register index localparams: `MTIME_LO_IDX`…`PRESCALE_IDX`.
  - `CTRL` bit positions: `CTRL_ENABLE_BIT`, `CTRL_IRQ_EN_BIT`.
- One natural sub-module: `mtimer_prescaler`, which produces the tick pulse. It is instantiated only under `MTIMER_PRESCALER_EN`; otherwise tick = `enable`.

## Test plan
- Reset, then read all 8 indices: all read 0 except `MTIMECMP_LO`/`HI` = 32'hFFFF_FFFF; `timer_irq`=0.
- Write `MTIME_LO`=32'hFFFF_FFFE, `MTIME_HI`=0, `CTRL`=1, wait 3 cycles, then read LO followed by HI: LO = 32'h0000_0001 ± pipeline offset (checked exactly against the model) and HI = 1 (carry across halves); a HI read before the next LO read still returns 1.
- Set `mtimecmp`=10, `CTRL`=3, `mtime`=0: `timer_irq` rises exactly 1 cycle after `mtime` reaches 10. Writing `MTIMECMP_LO`=100 drops it on the following cycle.
- Write `MTIME_LO`=5 on a tick cycle with `enable`=1: the next read returns 5 plus only the ticks after the write edge. Asserting `read`+`write` together leaves `read_data` unchanged.
- With `MTIMER_PRESCALER_EN`, `PRESCALE`=3, `enable`=1: `mtime` advances once per 4 cycles; after 40 cycles `mtime`=10. Without the macro, writing `PRESCALE`=3 and reading it back returns 0.
- Assert `reset` mid-count with `timer_irq`=1: on the next cycle all registers are at reset values and `timer_irq`=0.
